// File: rtl/fetch_seq_pkg.sv
// Shared encodings for the fetch sequencer: FSM states, branch opcodes,
// condition codes and status-flag bit positions.
package fetch_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_EXEC,
    ST_UPDATE
  } state_t;

  localparam logic [3:0] OP_BCOND  = 4'b1100;
  localparam logic [3:0] OP_JCOND  = 4'b0100;
  localparam logic [3:0] JCOND_SUB = 4'b1100;

  localparam logic [3:0] CC_EQ = 4'h0;
  localparam logic [3:0] CC_NE = 4'h1;
  localparam logic [3:0] CC_CS = 4'h2;
  localparam logic [3:0] CC_CC = 4'h3;
  localparam logic [3:0] CC_HI = 4'h4;
  localparam logic [3:0] CC_LS = 4'h5;
  localparam logic [3:0] CC_GT = 4'h6;
  localparam logic [3:0] CC_LE = 4'h7;
  localparam logic [3:0] CC_FS = 4'h8;
  localparam logic [3:0] CC_FC = 4'h9;
  localparam logic [3:0] CC_LO = 4'hA;
  localparam logic [3:0] CC_HS = 4'hB;
  localparam logic [3:0] CC_LT = 4'hC;
  localparam logic [3:0] CC_GE = 4'hD;
  localparam logic [3:0] CC_AL = 4'hE;
  localparam logic [3:0] CC_NV = 4'hF;

  localparam int FLAG_Z = 4;
  localparam int FLAG_C = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_F = 1;
  localparam int FLAG_L = 0;

  function automatic logic is_bcond(input logic [15:0] w);
    return w[15:12] == OP_BCOND;
  endfunction

  function automatic logic is_jcond(input logic [15:0] w);
    return (w[15:12] == OP_JCOND) && (w[7:4] == JCOND_SUB);
  endfunction

endpackage

// File: rtl/cond_eval.sv
// Combinational branch-condition evaluator: maps a 4-bit condition code and
// the {Z,C,N,F,L} flags to a single take bit.
module cond_eval
  import fetch_seq_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [4:0] flags,
  output logic       take
);

  logic z, c, n, f, l;

  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign n = flags[FLAG_N];
  assign f = flags[FLAG_F];
  assign l = flags[FLAG_L];

  always_comb begin
    take = 1'b0;
    case (cond)
      CC_EQ:   take = z;
      CC_NE:   take = !z;
      CC_CS:   take = c;
      CC_CC:   take = !c;
      CC_HI:   take = l;
      CC_LS:   take = !l;
      CC_GT:   take = n;
      CC_LE:   take = !n;
      CC_FS:   take = f;
      CC_FC:   take = !f;
      CC_LO:   take = !l && !z;
      CC_HS:   take = l || z;
      CC_LT:   take = !n && !z;
      CC_GE:   take = n || z;
      CC_AL:   take = 1'b1;
      CC_NV:   take = 1'b0;
      default: take = 1'b0;
    endcase
  end

endmodule

// File: rtl/fetch_seq.sv
// Instruction fetch/issue sequencer: fetch, wait MEM_LAT cycles, latch ir,
// then either hand off to the datapath or resolve a branch and update the PC.
module fetch_seq
  import fetch_seq_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] pc,
  output logic [15:0] mem_addr,
  output logic        mem_rd_en,
  input  logic [15:0] mem_rdata,
  input  logic        stall,
  input  logic [4:0]  flags,
  output logic [15:0] ir,
  output logic        exec_go,
  input  logic        exec_done,
  output logic [3:0]  rtgt_addr,
  input  logic [15:0] rtgt_data,
  output logic        pc_en,
  output logic        ld_pc_en,
  output logic        wr_pc,
  output logic [7:0]  ld_pc_disp,
  output logic [15:0] ld_pc
);

  localparam logic [1:0] WAIT_LAST = 2'(MEM_LAT - 1);

  state_t      state_q, state_d;
  logic [1:0]  wait_cnt_q, wait_cnt_d;
  logic [15:0] ir_q, ir_d;
  logic        go_pend_q, go_pend_d;

  logic rd_c, go_c, pc_en_c, ld_c, wr_c;
  logic take;

  cond_eval u_cond_eval (
    .cond  (ir_q[11:8]),
    .flags (flags),
    .take  (take)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= 2'd0;
      ir_q       <= 16'h0000;
      go_pend_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      ir_q       <= ir_d;
      go_pend_q  <= go_pend_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    ir_d       = ir_q;
    go_pend_d  = 1'b0;
    rd_c       = 1'b0;
    go_c       = 1'b0;
    pc_en_c    = 1'b0;
    ld_c       = 1'b0;
    wr_c       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!stall) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        rd_c       = 1'b1;
        wait_cnt_d = 2'd0;
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        if (wait_cnt_q == WAIT_LAST) begin
          ir_d = mem_rdata;
          // Branches resolve directly in UPDATE; everything else needs the datapath.
          if (is_bcond(mem_rdata) || is_jcond(mem_rdata)) begin
            state_d = ST_UPDATE;
          end else begin
            state_d   = ST_EXEC;
            go_pend_d = 1'b1;
          end
        end else begin
          wait_cnt_d = wait_cnt_q + 2'd1;
        end
      end
      ST_EXEC: begin
        go_c = go_pend_q;
        if (exec_done) state_d = ST_UPDATE;
      end
      ST_UPDATE: begin
        pc_en_c = 1'b1;
        ld_c    = is_bcond(ir_q) && take;
        wr_c    = is_jcond(ir_q) && take;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Strobes are forced low for the whole reset window, including the first edge.
  assign mem_rd_en  = rd_c && reset;
  assign exec_go    = go_c && reset;
  assign pc_en      = pc_en_c && reset;
  assign ld_pc_en   = ld_c && reset;
  assign wr_pc      = wr_c && reset;

  assign mem_addr   = pc;
  assign ir         = ir_q;
  assign rtgt_addr  = ir_q[3:0];
  assign ld_pc_disp = ir_q[7:0];
  assign ld_pc      = rtgt_data;

endmodule
